prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Runtime-programmable integer clock divider with programmable high time, glitch-free reconfiguration at period boundaries, and a clean stop on enable deassertion. It is the parametrised successor to the fixed even-N divider. It supports any divisor from 2 to 2^DIV_W−1, odd or even, with arbitrary duty. It also provides single-cycle edge strobes for logic that must stay in the `clk` domain. It sits between a control/CSR block and downstream timing consumers: baud generators, sensor clocks, PWM-like strobes.

## Interface
- `DIV_W`, 8, width of the divisor and high-time fields
- `RESET_DIV`, 4, active divisor after reset; must be legal
- `RESET_HIGH`, 2, active high time after reset; must be legal
- `clk`  input  1  system clock, all logic on posedge
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  run request; level-sensitive
- `cfg_valid`  input  1  new configuration offered
- `cfg_div`  input  DIV_W  requested period, in `clk` cycles
- `cfg_high`  input  DIV_W  requested high time, in `clk` cycles
- `cfg_ready`  output  1  shadow slot empty; a configuration can be accepted
- `cfg_err`  output  1  one-cycle pulse: offered configuration rejected as illegal
- `clk_out`  output  1  divided clock, registered
- `rise_pulse`  output  1  high in the cycle where `clk_out` is high for the first cycle of a period
- `fall_pulse`  output  1  high in the first cycle in which `clk_out` is low within a period
- `running`  output  1  FSM is in RUN

## Operation
- **Legality rule.** A configuration is legal when `div` ≥ 2 and 1 ≤ `high` ≤ `div`−1. All comparisons are unsigned at DIV_W bits.
- **Configuration handshake.**
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high.
  - An illegal configuration is dropped. `cfg_err` is 1 in the next cycle, and `cfg_ready` stays 1.
  - A legal configuration is written to the shadow register, and `cfg_ready` goes 0 in the next cycle.
- **Shadow apply.**
  - In IDLE, the shadow is copied to the active registers in the cycle after acceptance.
  - In RUN, the shadow is copied only on a boundary cycle (`cnt` = `div_act`−1), so it takes effect from `cnt` = 0 of the new period.
  - `cfg_ready` returns to 1 in the cycle after the copy.
- **FSM states:** IDLE and RUN.
  - **IDLE:** `cnt` = 0 and `clk_out` = 0. When `en` = 1, go to RUN.
  - **RUN:** `cnt` increments by 1 per cycle. On a boundary cycle, `cnt` wraps to 0 and the FSM stays in RUN if `en` = 1; otherwise it goes to IDLE.
  - **Clean stop:** `en` dropping mid-period never truncates the period. The current period completes.
- **Output and strobes.**
  - In RUN, `clk_out` = (`cnt` < `high_act`), registered so that it is aligned with `cnt`.
  - `rise_pulse` = RUN and `cnt` = 0.
  - `fall_pulse` = RUN and `cnt` = `high_act`.
- **Simultaneous events.**
  - A configuration accepted on a boundary cycle applies at the following boundary, not the current one.
  - If `en` drops and rises again before the boundary, there is no gap. The stop is cancelled.

## Timing
- **Reset values** (in the cycle after `rst` is sampled high):
  - `cnt` = 0, FSM in IDLE.
  - `div_act` = `RESET_DIV`, `high_act` = `RESET_HIGH`, shadow empty.
  - `cfg_ready` = 1.
  - `cfg_err`, `clk_out`, `rise_pulse`, `fall_pulse` and `running` = 0.
- **Reset mid-operation:** outputs go low in the next cycle, and any pending shadow configuration is discarded.
- **Start latency:** `en` is sampled high in IDLE at cycle t. In cycle t+1, `running` = 1, `clk_out` = 1 and `rise_pulse` = 1.
- **Period:** exactly `div_act` cycles. `clk_out` is high for exactly `high_act` cycles per period.
- **Stop:** the last period ends with `clk_out` = 0. `running` = 0 in the cycle after the boundary.
- **Glitch freedom:** no runt or stretched phase is ever produced by reconfiguration.

## Structure
- **Package `clk_div_pkg`:** contains
  - the `state_e` enum (IDLE, RUN);
  - the function `cfg_legal(div, high)`.
- **Sub-module `clk_div_cfg_shadow`:** contains the handshake, the legality check, the shadow register and the apply strobe.
- **Top level:** the FSM, the counter and the output registers.

## Test plan
- **Reset defaults:** reset, then `en` = 1 for 12 cycles → `clk_out` pattern 1100 repeating, `rise_pulse` every 4 cycles, `cfg_ready` = 1.
- **Odd divisor:** offer `div` = 5, `high` = 2 in IDLE → accepted. After `en`, the period is 5 cycles, 2 high and 3 low, and `fall_pulse` fires at `cnt` = 2.
- **Illegal configurations:** offer `div` = 1; `div` = 6, `high` = 0; `div` = 6, `high` = 6 → `cfg_err` pulses once for each. Active settings are unchanged, and `cfg_ready` stays 1.
- **Mid-run reconfiguration:** running at 4/2, offer 7/3 at `cnt` = 1 → the current period completes as 4/2, the next is 7/3, and `cfg_ready` = 0 until the apply.
- **Boundary collision:** offer 3/1 exactly on a boundary cycle → one more full 4/2 period occurs before 3/1 takes effect.
- **Clean stop and reset:** drop `en` at `cnt` = 0 → the full period completes, then IDLE. Separately, assert `rst` at `cnt` = 1 with a pending shadow → outputs low next cycle, shadow discarded, active settings back to 4/2.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Arguments are zero-extended by callers so one function serves any DIV_W up to 32.
  function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Configuration handshake, legality check and single-entry shadow register.
module clk_div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic             apply_ok,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             apply,
  output logic [DIV_W-1:0] shadow_div,
  output logic [DIV_W-1:0] shadow_high
);

  logic full;

  assign cfg_ready = ~full;
  // Accept and apply never coincide: accept needs an empty slot, apply a full one.
  assign apply     = full & apply_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      cfg_err     <= 1'b0;
      shadow_div  <= '0;
      shadow_high <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_valid && !full) begin
        if (cfg_legal(32'(cfg_div), 32'(cfg_high))) begin
          full        <= 1'b1;
          shadow_div  <= cfg_div;
          shadow_high <= cfg_high;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (apply) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with period-boundary reconfiguration
// and clean stop; all outputs registered and aligned with the period counter.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RESET_DIV  = 4,
  parameter int unsigned RESET_HIGH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             running
);

  state_e           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] high_act;
  logic [DIV_W-1:0] shadow_div;
  logic [DIV_W-1:0] shadow_high;
  logic             boundary;
  logic             apply;

  assign cnt_inc  = cnt + 1'b1;
  assign boundary = (state == RUN) && (cnt == div_act - 1'b1);

  clk_div_cfg_shadow #(
    .DIV_W (DIV_W)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .apply_ok    ((state == IDLE) || boundary),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .apply       (apply),
    .shadow_div  (shadow_div),
    .shadow_high (shadow_high)
  );

  // Outputs are computed from the next counter value so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_act    <= DIV_W'(RESET_DIV);
      high_act   <= DIV_W'(RESET_HIGH);
      clk_out    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      running    <= 1'b0;
    end else begin
      if (apply) begin
        div_act  <= shadow_div;
        high_act <= shadow_high;
      end
      case (state)
        IDLE: begin
          cnt        <= '0;
          fall_pulse <= 1'b0;
          if (en) begin
            state      <= RUN;
            clk_out    <= 1'b1;
            rise_pulse <= 1'b1;
            running    <= 1'b1;
          end else begin
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            running    <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt        <= '0;
            fall_pulse <= 1'b0;
            if (en) begin
              clk_out    <= 1'b1;
              rise_pulse <= 1'b1;
              running    <= 1'b1;
            end else begin
              state      <= IDLE;
              clk_out    <= 1'b0;
              rise_pulse <= 1'b0;
              running    <= 1'b0;
            end
          end else begin
            cnt        <= cnt_inc;
            clk_out    <= (cnt_inc < high_act);
            rise_pulse <= 1'b0;
            fall_pulse <= (cnt_inc == high_act);
            running    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider.
module tb_prog_clock_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       running;

  int vectors = 0;
  int errs    = 0;

  prog_clock_divider #(
    .DIV_W      (8),
    .RESET_DIV  (4),
    .RESET_HIGH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Bundle order: {clk_out, rise_pulse, fall_pulse, running}
  task automatic chk_o(input string tag, input logic c, input logic r, input logic f, input logic u);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {clk_out, rise_pulse, fall_pulse, running};
    exp = {c, r, f, u};
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed clk/rise/fall/run=%b expected %b", tag, obs, exp);
    end
  endtask

  // Checks n consecutive RUN cycles starting at the current cycle with counter k0.
  task automatic run_cycles(input string tag, input int d, input int h, input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      if (i > 0) step();
      k = (k0 + i) % d;
      chk_o($sformatf("%s_k%0d", tag, k), k < h, k == 0, k == h, 1'b1);
    end
  endtask

  task automatic cfg_idle(input logic [7:0] d, input logic [7:0] h);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_high  = h;
    step();
    cfg_valid = 1'b0;
    chk("cfg_acc_ready", cfg_ready, 1'b0);
    chk("cfg_acc_err", cfg_err, 1'b0);
    step();
    chk("cfg_apply_ready", cfg_ready, 1'b1);
  endtask

  task automatic illegal(input logic [7:0] d, input logic [7:0] h);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_high  = h;
    step();
    cfg_valid = 1'b0;
    chk($sformatf("ill_%0d_%0d_err", d, h), cfg_err, 1'b1);
    chk($sformatf("ill_%0d_%0d_ready", d, h), cfg_ready, 1'b1);
    step();
    chk($sformatf("ill_%0d_%0d_err_clr", d, h), cfg_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;
    step();
    step();
    chk_o("rst_out", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_err", cfg_err, 1'b0);

    // Reset defaults 4/2 and start latency
    rst = 1'b0;
    en  = 1'b1;
    step();
    run_cycles("dflt", 4, 2, 0, 12);
    chk("dflt_ready", cfg_ready, 1'b1);

    // Clean stop: en drops at cnt = 0, period completes
    step();
    chk_o("stop_k0", 1'b1, 1'b1, 1'b0, 1'b1);
    en = 1'b0;
    step();
    run_cycles("stop", 4, 2, 1, 3);
    step();
    chk_o("stop_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_o("stop_idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Odd divisor 5/2
    cfg_idle(8'd5, 8'd2);
    en = 1'b1;
    step();
    run_cycles("odd", 5, 2, 0, 10);
    en = 1'b0;
    step();
    chk_o("odd_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal configurations leave 5/2 active
    illegal(8'd1, 8'd1);
    illegal(8'd6, 8'd0);
    illegal(8'd6, 8'd6);
    en = 1'b1;
    step();
    run_cycles("keep", 5, 2, 0, 5);
    en = 1'b0;
    step();
    chk_o("keep_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-run reconfiguration 4/2 -> 7/3 offered at cnt = 1
    cfg_idle(8'd4, 8'd2);
    en = 1'b1;
    step();
    run_cycles("mid_a", 4, 2, 0, 2);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    cfg_high  = 8'd3;
    step();
    cfg_valid = 1'b0;
    chk("mid_ready_k2", cfg_ready, 1'b0);
    run_cycles("mid_b", 4, 2, 2, 2);
    chk("mid_ready_k3", cfg_ready, 1'b0);
    step();
    chk("mid_ready_new", cfg_ready, 1'b1);
    run_cycles("mid_new", 7, 3, 0, 7);
    en = 1'b0;
    step();
    chk_o("mid_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Boundary collision: 3/1 offered on the boundary cycle of a 4/2 period
    cfg_idle(8'd4, 8'd2);
    en = 1'b1;
    step();
    run_cycles("col_a", 4, 2, 0, 4);
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    cfg_high  = 8'd1;
    step();
    cfg_valid = 1'b0;
    chk("col_ready", cfg_ready, 1'b0);
    run_cycles("col_b", 4, 2, 0, 4);
    step();
    chk("col_ready_new", cfg_ready, 1'b1);
    run_cycles("col_new", 3, 1, 0, 6);

    // Reset at cnt = 1 with a pending 5/3 shadow
    step();
    chk_o("prerst_k0", 1'b1, 1'b1, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    cfg_high  = 8'd3;
    step();
    cfg_valid = 1'b0;
    chk_o("prerst_k1", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("prerst_ready", cfg_ready, 1'b0);
    rst = 1'b1;
    step();
    chk_o("rst_mid_out", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    step();
    run_cycles("post_rst", 4, 2, 0, 8);
    en = 1'b0;
    step();
    chk_o("final_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
